// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 status/interrupt unit: register numbers,
// exception codes and bit positions inside SR and Cause.
package cp0_pkg;

  localparam logic [31:0] PRID    = 32'h4D49_5053;
  localparam int          HWINT_W = 6;

  // CP0 register numbers.
  localparam logic [4:0] SEL_BADVADDR = 5'd8;
  localparam logic [4:0] SEL_SR       = 5'd12;
  localparam logic [4:0] SEL_CAUSE    = 5'd13;
  localparam logic [4:0] SEL_EPC      = 5'd14;
  localparam logic [4:0] SEL_PRID     = 5'd15;

  // ExcCode values.
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // SR bit positions.
  localparam int SR_IE  = 0;
  localparam int SR_EXL = 1;
  localparam int IM_LO  = 10;
  localparam int IM_HI  = IM_LO + HWINT_W - 1;

  // Cause bit positions (IP shares the IM positions).
  localparam int IP_LO    = 10;
  localparam int IP_HI    = IP_LO + HWINT_W - 1;
  localparam int EXC_LO   = 2;
  localparam int EXC_HI   = 6;
  localparam int CAUSE_BD = 31;

endpackage

// File: rtl/cp0_irq_gate.sv
// Interrupt gate: samples the device lines into IP every cycle and
// qualifies them with the SR mask, global enable and exception level.
module cp0_irq_gate
  import cp0_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [HWINT_W-1:0] hwint,
  input  logic [HWINT_W-1:0] im,
  input  logic               ie,
  input  logic               exl,
  output logic [HWINT_W-1:0] ip,
  output logic               int_req
);

  // IP follows the device lines with one cycle of latency; it is not sticky.
  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ip <= '0;
    else        ip <= hwint;
  end

  // Request is built only from registered state, so it is glitch-free
  // relative to this cycle's inputs.
  assign int_req = (|(ip & im)) & ie & ~exl;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 status/interrupt unit: SR, Cause, EPC, PRId and optional
// BadVAddr, with mfc0/mtc0 access and exception entry/return handling.
// Optional feature macro: CP0_BADVADDR_EN (adds BadVAddr at sel 8).
module cp0_unit
  import cp0_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         sel,
  input  logic [31:0]        din,
  input  logic               we,
  output logic [31:0]        dout,
  input  logic [HWINT_W-1:0] hwint,
  input  logic [31:0]        pc,
  input  logic               bd,
  input  logic [4:0]         exc_code,
  input  logic [31:0]        badvaddr,
  input  logic               exl_set,
  input  logic               exl_clr,
  output logic [31:0]        epc,
  output logic               int_req
);

  logic [HWINT_W-1:0] im;
  logic               exl;
  logic               ie;
  logic               bd_q;
  logic [4:0]         exc_q;
  logic [29:0]        epc_q;
  logic [HWINT_W-1:0] ip;
  logic [29:0]        epc_entry;
  logic               wr_sr;
  logic               wr_epc;
  logic               unused_pc_lsb;

  assign wr_sr  = we && (sel == SEL_SR);
  assign wr_epc = we && (sel == SEL_EPC);

  // A delay-slot fault restarts at the branch, one word earlier; the word
  // address is all that is kept, so bits [1:0] read back as zero.
  assign epc_entry     = bd ? (pc[31:2] - 30'd1) : pc[31:2];
  assign unused_pc_lsb = ^pc[1:0];

  // SR fields: mtc0 first, then eret, then exception entry, so the later
  // assignment takes priority on EXL while IM/IE keep the mtc0 write.
  // NOTE: priority comes from statement order -- the last non-blocking
  // assignment to a register in the same edge is the one that lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im  <= '0;
      exl <= 1'b0;
      ie  <= 1'b0;
    end else begin
      if (wr_sr) begin
        im  <= din[IM_HI:IM_LO];
        exl <= din[SR_EXL];
        ie  <= din[SR_IE];
      end
      if (exl_clr) exl <= 1'b0;
      if (exl_set) exl <= 1'b1;
    end
  end

  // Cause BD/ExcCode are only loaded by exception entry; mtc0 cannot touch them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bd_q  <= 1'b0;
      exc_q <= EXC_INT;
    end else if (exl_set) begin
      bd_q  <= bd;
      exc_q <= exc_code;
    end
  end

  // EPC: software-writable, but exception entry overrides a same-cycle write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       epc_q <= '0;
    else if (exl_set) epc_q <= epc_entry;
    else if (wr_epc)  epc_q <= din[31:2];
  end

`ifdef CP0_BADVADDR_EN
  logic [31:0] badvaddr_q;

  // BadVAddr captures the address only for address-error exceptions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) badvaddr_q <= '0;
    else if (exl_set && (exc_code == EXC_ADEL || exc_code == EXC_ADES))
      badvaddr_q <= badvaddr;
  end
`else
  logic unused_badvaddr;
  assign unused_badvaddr = ^badvaddr;
`endif

  cp0_irq_gate u_irq_gate (
    .clk     (clk),
    .reset   (reset),
    .hwint   (hwint),
    .im      (im),
    .ie      (ie),
    .exl     (exl),
    .ip      (ip),
    .int_req (int_req)
  );

  assign epc = {epc_q, 2'b00};

  // mfc0 read mux: registered state only, never the same-cycle din.
  // NOTE: dout gets a default before the case so unlisted sel values
  // cannot infer a latch.
  always_comb begin
    dout = '0;
    case (sel)
      SEL_SR: begin
        dout[IM_HI:IM_LO] = im;
        dout[SR_EXL]      = exl;
        dout[SR_IE]       = ie;
      end
      SEL_CAUSE: begin
        dout[CAUSE_BD]      = bd_q;
        dout[IP_HI:IP_LO]   = ip;
        dout[EXC_HI:EXC_LO] = exc_q;
      end
      SEL_EPC:      dout = {epc_q, 2'b00};
      SEL_PRID:     dout = PRID;
`ifdef CP0_BADVADDR_EN
      SEL_BADVADDR: dout = badvaddr_q;
`endif
      default:      dout = '0;
    endcase
  end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 status/interrupt unit for the pipelined MIPS CPU. Latches hardware interrupt lines from the memory-mapped devices (timer `IntReq` on `hwint[2]`), applies the Status-register mask and global enable, and raises `int_req` to the pipeline. On exception entry it captures EPC, ExcCode and BD; on `eret` it releases EXL. It also services `mfc0`/`mtc0` accesses.

## Interface
- `PRID`, 32'h4D49_5053, read-only value of the PRId register (sel 15)
- `HWINT_W`, 6, number of hardware interrupt lines, mapped to IP[15:10]
- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset); one clock, reset is asynchronous and active-low
- `sel`  in  5  CP0 register number for read/write
- `din`  in  32  `mtc0` write data
- `we`  in  1  `mtc0` write strobe
- `dout`  out  32  `mfc0` read data, combinational from `sel`
- `hwint`  in  HWINT_W  device interrupt lines, level-sensitive, same clock domain
- `pc`  in  32  PC of the instruction taking the exception
- `bd`  in  1  faulting instruction sits in a branch delay slot
- `exc_code`  in  5  cause code for this exception (0 = interrupt)
- `badvaddr`  in  32  faulting address (used only with `CP0_BADVADDR_EN`)
- `exl_set`  in  1  exception entry strobe
- `exl_clr`  in  1  `eret` strobe
- `epc`  out  32  current EPC, for `eret` redirect
- `int_req`  out  1  interrupt request to pipeline

## Operation
- Registers: SR (sel 12: IM[15:10], EXL[1], IE[0], other bits read 0), Cause (sel 13: BD[31], IP[15:10], ExcCode[6:2], others 0), EPC (sel 14), PRId (sel 15), BadVAddr (sel 8, optional). Unlisted sel reads 0.
- IP[15:10] <= `hwint` every cycle, unconditionally (not sticky; device must hold its line until cleared by software).
- `int_req` = |(IP & IM) & IE & ~EXL, combinational from registered state.
- `exl_set`: EXL<=1; ExcCode<=`exc_code`; BD<=`bd`; EPC<=(`bd` ? `pc`-4 : `pc`) with bits[1:0] forced 0.
- `exl_clr`: EXL<=0. Simultaneous `exl_set` and `exl_clr`: `exl_set` wins.
- `mtc0`: sel 12 writes IM, EXL, IE only; sel 14 writes EPC (bits[1:0] forced 0); sel 13, 15 writes ignored. `exl_set` in the same cycle overrides `mtc0` on any field it updates; non-overlapping fields (e.g. IM) still take the write.
- Reset: SR=0, Cause=0, EPC=0, BadVAddr=0; hence `int_req`=0, `epc`=0, `dout`=PRID when sel=15 else 0.

## Timing
- `hwint` assert at edge N → IP set at N → `int_req` high after N (1-cycle latency), if unmasked.
- `mtc0` to SR at edge N → new mask/enable effective on `int_req` after N.
- `exl_set` at edge N → `int_req` low after N; `epc` valid after N.
- `dout` purely combinational: reflects register state after the most recent edge, never bypasses same-cycle `din`.
- Reset asserted mid-operation clears all state immediately, independent of `clk`.

## Configuration
- `CP0_BADVADDR_EN` defined: BadVAddr register at sel 8; on `exl_set` with `exc_code` 4 (AdEL) or 5 (AdES) it loads `badvaddr`, otherwise it holds its value. Read-only to `mtc0`.
- Undefined: no BadVAddr storage; sel 8 reads 0; `badvaddr` port present but ignored.

## Structure
- Package `cp0_pkg`: register numbers (SR=12, CAUSE=13, EPC=14, PRID=15, BADVADDR=8), ExcCode constants (INT=0, ADEL=4, ADES=5, RI=10, OV=12), SR/Cause bit-position constants.
- One sub-module `cp0_irq_gate`: holds IP register, computes `int_req` from IP, IM, IE, EXL.

## Test plan
- Reset low, then release: all reads 0 except sel 15 = 32'h4D49_5053; `int_req`=0; `epc`=0.
- `mtc0` sel 12 ← 32'h0000_0401 (IM[10], IE); drive `hwint`=6'b000001 → `int_req`=1 one cycle later; drop `hwint` → `int_req`=0 one cycle later.
- With interrupt pending, pulse `exl_set`, `pc`=32'h0000_3010, `bd`=1, `exc_code`=0 → `epc`=32'h0000_300C, Cause read = 32'h8000_0400, `int_req`=0; pulse `exl_clr` → `int_req`=1.
- `exl_set` and `exl_clr` same cycle → EXL=1; `exl_set` plus `mtc0` sel 14 ← 32'h1234_5678 → EPC = `pc` value, not din.
- `mtc0` sel 13 ← 32'hFFFF_FFFF and sel 15 ← 0 → both reads unchanged; `mtc0` sel 14 ← 32'h0000_3003 → reads 32'h0000_3000.
- With `CP0_BADVADDR_EN`: `exl_set`, `exc_code`=4, `badvaddr`=32'h0000_0ABD → sel 8 reads 32'h0000_0ABD; following `exl_set` with `exc_code`=12 leaves it unchanged. Without the macro, sel 8 reads 0.
